fb_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single Avalon-MM path to the SDRAM controller between the VGA line-fetch reader (read bursts, latency-critical) and the game-logic framebuffer writer (write bursts). It sits between both masters and the SDRAM controller slave in the system. Fixed VGA priority, bounded by a writer anti-starvation streak limit and an outstanding-read credit limit.

---
 rtl/fb_mem_arbiter_if.sv | 59 +++++
 rtl/fb_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// ============================================================================
// Module   : fb_mem_arbiter_if
// Purpose  : Avalon-MM signal bundle for the VGA reader, the framebuffer
//            writer and the SDRAM controller path around fb_mem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fb_mem_arbiter_if #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]   vga_address;
  logic                vga_read;
  logic [BURST_W-1:0]  vga_burstcount;
  logic                vga_waitrequest;
  logic [DATA_W-1:0]   vga_readdata;
  logic                vga_readdatavalid;

  logic [ADDR_W-1:0]   wr_address;
  logic                wr_write;
  logic [DATA_W-1:0]   wr_writedata;
  logic [DATA_W/8-1:0] wr_byteenable;
  logic [BURST_W-1:0]  wr_burstcount;
  logic                wr_waitrequest;

  logic [ADDR_W-1:0]   m_address;
  logic [BURST_W-1:0]  m_burstcount;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_read;
  logic                m_write;
  logic                m_waitrequest;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;

  // Arbiter view: slave to both requesters, master towards the controller.
  modport slave (
    input  vga_address, vga_read, vga_burstcount,
    output vga_waitrequest, vga_readdata, vga_readdatavalid,
    input  wr_address, wr_write, wr_writedata, wr_byteenable, wr_burstcount,
    output wr_waitrequest,
    output m_address, m_burstcount, m_writedata, m_byteenable, m_read, m_write,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  // System view: the requesters and the controller around the arbiter.
  modport master (
    output vga_address, vga_read, vga_burstcount,
    input  vga_waitrequest, vga_readdata, vga_readdatavalid,
    output wr_address, wr_write, wr_writedata, wr_byteenable, wr_burstcount,
    input  wr_waitrequest,
    input  m_address, m_burstcount, m_writedata, m_byteenable, m_read, m_write,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/fb_mem_arbiter.sv
// ============================================================================
// Module   : fb_mem_arbiter
// Purpose  : VGA-priority arbiter sharing one SDRAM Avalon-MM path with the
//            framebuffer writer, with writer streak and read-credit limits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_mem_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int BURST_W     = 4,
  parameter int MAX_PENDING = 32,
  parameter int VGA_STREAK  = 4
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  fb_mem_arbiter_if.slave bus
);
  localparam int c_PEND_W   = $clog2(MAX_PENDING + 1);
  localparam int c_SUM_W    = c_PEND_W + BURST_W;
  localparam int c_STREAK_W = $clog2(VGA_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(VGA_STREAK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VGA  = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_PEND_W-1:0]   r_pending;
  logic [c_STREAK_W-1:0] r_streak;
  logic [BURST_W-1:0]    r_beats;
  logic                  r_wr_started;

  logic [BURST_W-1:0]    w_vga_eff;
  logic [BURST_W-1:0]    w_wr_eff;
  logic                  w_credit_ok;
  logic                  w_vga_acc;
  logic                  w_wr_acc;
  logic                  w_wr_last;
  logic [c_PEND_W-1:0]   w_pend_add;
  logic [c_PEND_W-1:0]   w_pend_sub;

  // A zero burstcount is treated as a single beat.
  assign w_vga_eff = (bus.vga_burstcount == '0) ? BURST_W'(1) : bus.vga_burstcount;
  assign w_wr_eff  = (bus.wr_burstcount  == '0) ? BURST_W'(1) : bus.wr_burstcount;

  assign w_credit_ok = (c_SUM_W'(r_pending) + c_SUM_W'(w_vga_eff)) <= c_SUM_W'(MAX_PENDING);

  assign w_vga_acc = (r_state == S_VGA) && bus.vga_read && !bus.m_waitrequest;
  assign w_wr_acc  = (r_state == S_WR)  && bus.wr_write && !bus.m_waitrequest;
  assign w_wr_last = w_wr_acc && (r_wr_started ? (r_beats == BURST_W'(1))
                                               : (w_wr_eff == BURST_W'(1)));

  assign w_pend_add = w_vga_acc ? c_PEND_W'(w_vga_eff) : '0;
  // Stray read data with nothing outstanding is dropped rather than wrapping.
  assign w_pend_sub = (bus.m_readdatavalid && (r_pending != '0)) ? c_PEND_W'(1) : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_streak     <= '0;
      r_beats      <= '0;
      r_wr_started <= 1'b0;
    end else begin
      r_pending <= r_pending + w_pend_add - w_pend_sub;
      case (r_state)
        S_IDLE: begin
          if (bus.vga_read && w_credit_ok && (!bus.wr_write || (r_streak < c_STREAK_MAX))) begin
            r_state <= S_VGA;
          end else if (bus.wr_write) begin
            r_state      <= S_WR;
            r_wr_started <= 1'b0;
          end
        end
        S_VGA: begin
          if (!bus.vga_read) begin
            r_state <= S_IDLE;
          end else if (!bus.m_waitrequest) begin
            r_state <= S_IDLE;
            if (!bus.wr_write) begin
              r_streak <= '0;
            end else if (r_streak < c_STREAK_MAX) begin
              r_streak <= r_streak + c_STREAK_W'(1);
            end
          end
        end
        S_WR: begin
          if (w_wr_acc) begin
            r_wr_started <= 1'b1;
            r_beats      <= r_wr_started ? (r_beats - BURST_W'(1)) : (w_wr_eff - BURST_W'(1));
          end
          if (w_wr_last) begin
            r_state      <= S_IDLE;
            r_streak     <= '0;
            r_wr_started <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic                w_m_read;
  logic                w_m_write;
  logic [ADDR_W-1:0]   w_m_address;
  logic [BURST_W-1:0]  w_m_burstcount;
  logic [DATA_W-1:0]   w_m_writedata;
  logic [DATA_W/8-1:0] w_m_byteenable;
  logic                w_vga_wait;
  logic                w_wr_wait;

  always_comb begin
    w_m_read       = 1'b0;
    w_m_write      = 1'b0;
    w_m_address    = '0;
    w_m_burstcount = '0;
    w_m_writedata  = '0;
    w_m_byteenable = '0;
    w_vga_wait     = 1'b1;
    w_wr_wait      = 1'b1;
    case (r_state)
      S_VGA: begin
        w_m_read       = bus.vga_read;
        w_m_address    = bus.vga_address;
        w_m_burstcount = bus.vga_burstcount;
        w_vga_wait     = bus.m_waitrequest;
      end
      S_WR: begin
        w_m_write      = bus.wr_write;
        w_m_address    = bus.wr_address;
        w_m_burstcount = bus.wr_burstcount;
        w_m_writedata  = bus.wr_writedata;
        w_m_byteenable = bus.wr_byteenable;
        w_wr_wait      = bus.m_waitrequest;
      end
      default: ;
    endcase
  end

  assign bus.m_read            = w_m_read;
  assign bus.m_write           = w_m_write;
  assign bus.m_address         = w_m_address;
  assign bus.m_burstcount      = w_m_burstcount;
  assign bus.m_writedata       = w_m_writedata;
  assign bus.m_byteenable      = w_m_byteenable;
  assign bus.vga_waitrequest   = w_vga_wait;
  assign bus.wr_waitrequest    = w_wr_wait;
  assign bus.vga_readdata      = bus.m_readdata;
  assign bus.vga_readdatavalid = bus.m_readdatavalid;

endmodule

`default_nettype wire

// File: tb/tb_fb_mem_arbiter.sv
// ============================================================================
// Module   : tb_fb_mem_arbiter
// Purpose  : Self-checking bench for fb_mem_arbiter (directed + random traffic).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fb_mem_arbiter;
  localparam int c_MAX_PENDING = 32;
  localparam int c_VGA_STREAK  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter_if #(.ADDR_W(24), .DATA_W(16), .BURST_W(4)) bus ();

  fb_mem_arbiter #(
    .ADDR_W(24), .DATA_W(16), .BURST_W(4),
    .MAX_PENDING(c_MAX_PENDING), .VGA_STREAK(c_VGA_STREAK)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.vga_address = '0; bus.vga_read = 1'b0; bus.vga_burstcount = '0;
    bus.wr_address = '0; bus.wr_write = 1'b0; bus.wr_writedata = '0;
    bus.wr_byteenable = '0; bus.wr_burstcount = '0;
    bus.m_waitrequest = 1'b0; bus.m_readdata = '0; bus.m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    bus.vga_read = 1'b1; bus.vga_burstcount = 4'd8; bus.vga_address = 24'h123456;
    bus.wr_write = 1'b1; bus.wr_burstcount = 4'd4; bus.wr_address = 24'h654321;
    bus.wr_writedata = 16'hA5A5; bus.wr_byteenable = 2'b11;
    tick();
    n_tests++;
    if ({bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, expected 0011",
               {bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest});
    end
    n_tests++;
    if (bus.m_address !== 24'h0 || bus.m_burstcount !== 4'h0 || bus.m_writedata !== 16'h0 ||
        bus.m_byteenable !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h bc=%h wd=%h be=%b, expected all zero",
               bus.m_address, bus.m_burstcount, bus.m_writedata, bus.m_byteenable);
    end
    n_tests++;
    if (dut.r_pending !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d, expected 0", dut.r_pending);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: got %b, expected 0011",
               {bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest});
    end
  endtask

  task automatic test_vga_burst;
    logic [23:0] addr;
    logic [15:0] d;
    do_reset();
    addr = 24'($urandom);
    bus.vga_read = 1'b1; bus.vga_burstcount = 4'd8; bus.vga_address = addr;
    #1;
    n_tests++;
    if (bus.m_read !== 1'b0 || bus.vga_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL vga_cycle0: got m_read=%b wait=%b, expected 0/1", bus.m_read, bus.vga_waitrequest);
    end
    tick();
    n_tests++;
    if (bus.m_read !== 1'b1 || bus.vga_waitrequest !== 1'b0 || bus.m_burstcount !== 4'd8 ||
        bus.m_address !== addr) begin
      n_fail++;
      $display("FAIL vga_cycle1: got m_read=%b wait=%b bc=%0d addr=%h, expected 1/0/8/%h",
               bus.m_read, bus.vga_waitrequest, bus.m_burstcount, bus.m_address, addr);
    end
    tick();
    bus.vga_read = 1'b0;
    #1;
    n_tests++;
    if (dut.r_pending !== 6'd8 || bus.m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL vga_pending_after_accept: got pending=%0d m_read=%b, expected 8/0",
               dut.r_pending, bus.m_read);
    end
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      bus.m_readdatavalid = 1'b1; bus.m_readdata = d;
      #1;
      n_tests++;
      if (bus.vga_readdatavalid !== 1'b1 || bus.vga_readdata !== d) begin
        n_fail++;
        $display("FAIL vga_return_beat%0d: got v=%b d=%h, expected 1/%h", i,
                 bus.vga_readdatavalid, bus.vga_readdata, d);
      end
      tick();
    end
    bus.m_readdatavalid = 1'b0;
    #1;
    n_tests++;
    if (dut.r_pending !== 6'd0) begin
      n_fail++;
      $display("FAIL vga_pending_drained: got %0d, expected 0", dut.r_pending);
    end
  endtask

  task automatic test_write_stall;
    logic [15:0] data [4];
    logic [23:0] addr;
    int b, first_c, last_c;
    logic stalled;
    do_reset();
    for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
    addr = 24'($urandom);
    bus.wr_write = 1'b1; bus.wr_address = addr; bus.wr_burstcount = 4'd4; bus.wr_byteenable = 2'b10;
    b = 0; first_c = -1; last_c = -1; stalled = 1'b0;
    for (int c = 0; c < 12 && b < 4; c++) begin
      bus.wr_writedata  = data[b];
      bus.m_waitrequest = (b == 1) && !stalled;
      #1;
      n_tests++;
      if (bus.vga_waitrequest !== 1'b1) begin
        n_fail++;
        $display("FAIL wr_vga_wait_c%0d: got %b, expected 1", c, bus.vga_waitrequest);
      end
      if (bus.m_write) begin
        n_tests++;
        if (bus.m_writedata !== data[b] || bus.m_address !== addr || bus.m_byteenable !== 2'b10) begin
          n_fail++;
          $display("FAIL wr_beat%0d_bus: got d=%h a=%h be=%b, expected %h/%h/10", b,
                   bus.m_writedata, bus.m_address, bus.m_byteenable, data[b], addr);
        end
        if (!bus.m_waitrequest) begin
          if (b == 0) first_c = c;
          last_c = c;
          b++;
        end else begin
          stalled = 1'b1;
        end
      end
      tick();
    end
    n_tests++;
    if (b != 4 || first_c != 1 || (last_c - first_c + 1) != 5) begin
      n_fail++;
      $display("FAIL wr_burst_span: got beats=%0d first=%0d span=%0d, expected 4/1/5",
               b, first_c, last_c - first_c + 1);
    end
    bus.wr_write = 1'b0; bus.m_waitrequest = 1'b0; bus.vga_read = 1'b1; bus.vga_burstcount = 4'd1;
    #1;
    n_tests++;
    if ({bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest} !== 4'b0011) begin
      n_fail++;
      $display("FAIL wr_back_to_idle: got %b, expected 0011",
               {bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest});
    end
    tick();
    n_tests++;
    if (bus.m_read !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_then_vga_grant: got m_read=%b, expected 1", bus.m_read);
    end
    bus.vga_read = 1'b0;
  endtask

  task automatic test_streak;
    string seq;
    int last_c;
    seq = "";
    last_c = -1;
    do_reset();
    bus.vga_read = 1'b1; bus.vga_burstcount = 4'd1;
    bus.wr_write = 1'b1; bus.wr_burstcount = 4'd1; bus.wr_byteenable = 2'b11;
    for (int c = 0; c < 60 && seq.len() < 15; c++) begin
      bus.wr_writedata = 16'($urandom);
      #1;
      if (bus.m_read && !bus.m_waitrequest) begin
        seq = {seq, "V"}; last_c = c;
      end else if (bus.m_write && !bus.m_waitrequest) begin
        seq = {seq, "W"}; last_c = c;
      end
      tick();
    end
    n_tests++;
    if (seq != "VVVVWVVVVWVVVVW") begin
      n_fail++;
      $display("FAIL streak_pattern: got %s, expected VVVVWVVVVWVVVVW", seq);
    end
    n_tests++;
    if (last_c != 29) begin
      n_fail++;
      $display("FAIL streak_rate: got 15th grant at cycle %0d, expected 29", last_c);
    end
    idle_inputs();
  endtask

  task automatic test_credit;
    int acc;
    acc = 0;
    do_reset();
    bus.vga_read = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.vga_burstcount = (acc < 4) ? 4'd8 : 4'd1;
      #1;
      if (bus.m_read && !bus.vga_waitrequest) acc++;
      tick();
    end
    n_tests++;
    if (acc != 4 || dut.r_pending !== 6'd32) begin
      n_fail++;
      $display("FAIL credit_fill: got accepts=%0d pending=%0d, expected 4/32", acc, dut.r_pending);
    end
    bus.m_readdatavalid = 1'b1;
    #1;
    n_tests++;
    if (bus.m_read !== 1'b0 || bus.vga_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_held: got m_read=%b wait=%b, expected 0/1", bus.m_read, bus.vga_waitrequest);
    end
    tick();
    bus.m_readdatavalid = 1'b0;
    #1;
    n_tests++;
    if (bus.m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_idle_eval: got m_read=%b, expected 0", bus.m_read);
    end
    tick();
    n_tests++;
    if (bus.m_read !== 1'b1 || bus.vga_waitrequest !== 1'b0 || bus.m_burstcount !== 4'd1) begin
      n_fail++;
      $display("FAIL credit_release: got m_read=%b wait=%b bc=%0d, expected 1/0/1",
               bus.m_read, bus.vga_waitrequest, bus.m_burstcount);
    end
    tick();
    bus.vga_read = 1'b0;
    #1;
    n_tests++;
    if (dut.r_pending !== 6'd32) begin
      n_fail++;
      $display("FAIL credit_pending_final: got %0d, expected 32", dut.r_pending);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    bus.vga_read = 1'b1; bus.vga_burstcount = 4'd5;
    tick();
    tick();
    bus.vga_burstcount = 4'd8;
    #1;
    n_tests++;
    if (dut.r_pending !== 6'd5) begin
      n_fail++;
      $display("FAIL simul_setup: got pending=%0d, expected 5", dut.r_pending);
    end
    tick();
    bus.m_readdatavalid = 1'b1; bus.m_readdata = 16'h1234;
    #1;
    n_tests++;
    if (bus.m_read !== 1'b1 || bus.m_burstcount !== 4'd8) begin
      n_fail++;
      $display("FAIL simul_accept: got m_read=%b bc=%0d, expected 1/8", bus.m_read, bus.m_burstcount);
    end
    tick();
    bus.m_readdatavalid = 1'b0; bus.vga_read = 1'b0;
    #1;
    n_tests++;
    if (dut.r_pending !== 6'd12) begin
      n_fail++;
      $display("FAIL simul_pending: got %0d, expected 12", dut.r_pending);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [15:0] data [4];
    int b;
    do_reset();
    for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
    bus.wr_write = 1'b1; bus.wr_address = 24'hABCDEF; bus.wr_burstcount = 4'd4; bus.wr_byteenable = 2'b11;
    b = 0;
    for (int c = 0; c < 10 && b < 2; c++) begin
      bus.wr_writedata = data[b];
      #1;
      if (bus.m_write && !bus.wr_waitrequest) b++;
      tick();
    end
    bus.wr_writedata = data[2];
    #1;
    n_tests++;
    if (b != 2 || bus.m_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got beats=%0d m_write=%b, expected 2/1", b, bus.m_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest} !== 4'b0011 ||
        bus.m_address !== 24'h0 || bus.m_burstcount !== 4'h0 || bus.m_writedata !== 16'h0 ||
        bus.m_byteenable !== 2'b00 || dut.r_pending !== 6'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got strobes=%b addr=%h bc=%h wd=%h be=%b, expected 0011 and zeros",
               {bus.m_read, bus.m_write, bus.vga_waitrequest, bus.wr_waitrequest},
               bus.m_address, bus.m_burstcount, bus.m_writedata, bus.m_byteenable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_writedata = data[0];
    #1;
    n_tests++;
    if (bus.m_write !== 1'b0 || bus.wr_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle: got m_write=%b wait=%b, expected 0/1", bus.m_write, bus.wr_waitrequest);
    end
    @(posedge clk);
    #1;
    b = 0;
    for (int c = 0; c < 10 && b < 4; c++) begin
      bus.wr_writedata = data[b];
      #1;
      if (c == 0) begin
        n_tests++;
        if (bus.m_write !== 1'b1 || bus.m_writedata !== data[0] || bus.wr_waitrequest !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_regrant: got m_write=%b d=%h wait=%b, expected 1/%h/0",
                   bus.m_write, bus.m_writedata, bus.wr_waitrequest, data[0]);
        end
      end
      if (bus.m_write && !bus.wr_waitrequest) b++;
      tick();
    end
    n_tests++;
    if (b != 4) begin
      n_fail++;
      $display("FAIL rstmid_complete: got %0d beats, expected 4", b);
    end
    idle_inputs();
  endtask

  task automatic test_random;
    logic        vact, wact, prev_end, rdv, vacc, wacc;
    int          vbc, wbc, wbeat, rq, mpend, wstreak;
    logic [23:0] vaddr, waddr;
    logic [15:0] wdata, rdata;
    logic [1:0]  wbe;
    do_reset();
    vact = 1'b0; wact = 1'b0; prev_end = 1'b0;
    vbc = 1; wbc = 1; wbeat = 0; rq = 0; mpend = 0; wstreak = 0;
    vaddr = '0; waddr = '0; wdata = '0; wbe = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!vact && $urandom_range(2) == 0) begin
        vact = 1'b1; vbc = int'($urandom_range(8, 1)); vaddr = 24'($urandom);
      end
      if (!wact && $urandom_range(2) == 0) begin
        wact = 1'b1; wbc = int'($urandom_range(8, 1)); wbeat = 0;
        waddr = 24'($urandom); wbe = 2'($urandom); wdata = 16'($urandom);
      end
      rdv   = (rq > 0) && ($urandom_range(1) == 1);
      rdata = 16'($urandom);
      bus.vga_read = vact; bus.vga_burstcount = 4'(vbc); bus.vga_address = vaddr;
      bus.wr_write = wact; bus.wr_burstcount = 4'(wbc); bus.wr_address = waddr;
      bus.wr_writedata = wdata; bus.wr_byteenable = wbe;
      bus.m_waitrequest = ($urandom_range(3) == 0);
      bus.m_readdatavalid = rdv; bus.m_readdata = rdata;
      #1;
      vacc = bus.m_read && !bus.m_waitrequest;
      wacc = bus.m_write && !bus.m_waitrequest;
      n_tests++;
      if ((bus.vga_read && !bus.vga_waitrequest) !== vacc || (bus.wr_write && !bus.wr_waitrequest) !== wacc) begin
        n_fail++;
        $display("FAIL rnd_handshake c%0d: got vacc=%b wacc=%b, expected master-side %b/%b", c,
                 bus.vga_read && !bus.vga_waitrequest, bus.wr_write && !bus.wr_waitrequest, vacc, wacc);
      end
      n_tests++;
      if ((bus.m_read && bus.m_write) || (prev_end && (bus.m_read || bus.m_write))) begin
        n_fail++;
        $display("FAIL rnd_idle_gap c%0d: got m_read=%b m_write=%b, expected idle", c, bus.m_read, bus.m_write);
      end
      n_tests++;
      if (bus.vga_readdatavalid !== rdv || (rdv && bus.vga_readdata !== rdata)) begin
        n_fail++;
        $display("FAIL rnd_return c%0d: got v=%b d=%h, expected %b/%h", c,
                 bus.vga_readdatavalid, bus.vga_readdata, rdv, rdata);
      end
      if (vacc) begin
        n_tests++;
        if (bus.m_address !== vaddr || bus.m_burstcount !== 4'(vbc) || mpend + vbc > c_MAX_PENDING) begin
          n_fail++;
          $display("FAIL rnd_read_cmd c%0d: got a=%h bc=%0d pend=%0d, expected %h/%0d with credit", c,
                   bus.m_address, bus.m_burstcount, mpend, vaddr, vbc);
        end
        if (wact) begin
          wstreak++;
          n_tests++;
          if (wstreak > c_VGA_STREAK) begin
            n_fail++;
            $display("FAIL rnd_starve c%0d: got %0d reads while writer waits, expected <= %0d",
                     c, wstreak, c_VGA_STREAK);
          end
        end else begin
          wstreak = 0;
        end
      end
      if (wacc) begin
        n_tests++;
        if (bus.m_address !== waddr || bus.m_writedata !== wdata || bus.m_byteenable !== wbe ||
            bus.m_burstcount !== 4'(wbc)) begin
          n_fail++;
          $display("FAIL rnd_write_beat c%0d: got a=%h d=%h be=%b bc=%0d, expected %h/%h/%b/%0d", c,
                   bus.m_address, bus.m_writedata, bus.m_byteenable, bus.m_burstcount,
                   waddr, wdata, wbe, wbc);
        end
      end
      prev_end = 1'b0;
      if (rdv) begin
        rq--;
        if (mpend > 0) mpend--;
      end
      if (vacc) begin
        mpend += vbc; rq += vbc; vact = 1'b0; prev_end = 1'b1;
      end
      if (wacc) begin
        wbeat++;
        wdata = 16'($urandom);
        if (wbeat == wbc) begin
          wact = 1'b0; wstreak = 0; prev_end = 1'b1;
        end
      end
      tick();
      n_tests++;
      if (dut.r_pending !== 6'(mpend)) begin
        n_fail++;
        $display("FAIL rnd_pending c%0d: got %0d, expected %0d", c, dut.r_pending, mpend);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_vga_burst();
    test_write_stall();
    test_streak();
    test_credit();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
